// File: rtl/btn_conditioner.sv
// Button input conditioning: per-channel 2-flop synchronizer, counter-based
// debouncer, registered press/release pulses and a stuck-button guard.
// The game FSM sees one clean press event per physical press, and a button
// held far too long is flagged stuck and stops generating presses.
module btn_conditioner #(
  parameter int N_BTN           = 8,
  parameter int DEBOUNCE_CYCLES = 200,
  parameter int HOLD_LIMIT      = 50000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] stuck,
  output logic             any_press
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = $clog2(HOLD_LIMIT + 1);

  // Last count before a changed level is accepted, and the hold saturation value.
  localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_LIMIT);

  logic [N_BTN-1:0]  sync1;
  logic [N_BTN-1:0]  sync2;

  logic [DB_W-1:0]   db_cnt   [N_BTN];
  logic [DB_W-1:0]   db_nxt   [N_BTN];
  logic [HOLD_W-1:0] hold_cnt [N_BTN];
  logic [HOLD_W-1:0] hold_nxt [N_BTN];

  logic [N_BTN-1:0]  level_nxt;
  logic [N_BTN-1:0]  stuck_nxt;
  logic [N_BTN-1:0]  press_nxt;
  logic [N_BTN-1:0]  release_nxt;

  // Two-flop synchronizer on the raw pins; runs even while conditioning is disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  // Next-state for debounce, hold/stuck tracking and edge pulses; everything holds and pulses are quiet when ena is low.
  always_comb begin
    level_nxt   = btn_level;
    stuck_nxt   = stuck;
    db_nxt      = db_cnt;
    hold_nxt    = hold_cnt;
    press_nxt   = '0;
    release_nxt = '0;

    if (ena) begin
      for (int i = 0; i < N_BTN; i++) begin
        // A changed level must persist for DEBOUNCE_CYCLES enabled cycles in a row.
        if (sync2[i] == btn_level[i]) begin
          db_nxt[i] = '0;
        end else if (db_cnt[i] == DB_LAST) begin
          level_nxt[i] = ~btn_level[i];
          db_nxt[i]    = '0;
        end else begin
          db_nxt[i] = db_cnt[i] + 1'b1;
        end

        // Pulses mark the first cycle of the new debounced level.
        press_nxt[i]   = level_nxt[i] & ~btn_level[i] & ~stuck[i];
        release_nxt[i] = ~level_nxt[i] & btn_level[i];

        // Hold time counts cycles the debounced level has already been high.
        // Clearing uses the new level so stuck drops with the release pulse.
        if (!level_nxt[i]) begin
          hold_nxt[i]  = '0;
          stuck_nxt[i] = 1'b0;
        end else if (btn_level[i] && (hold_cnt[i] != HOLD_MAX)) begin
          hold_nxt[i] = hold_cnt[i] + 1'b1;
          if (hold_nxt[i] == HOLD_MAX) begin
            stuck_nxt[i] = 1'b1;
          end
        end
      end
    end
  end

  // State and output registers, cleared immediately by the asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_level   <= '0;
      btn_press   <= '0;
      btn_release <= '0;
      stuck       <= '0;
      any_press   <= 1'b0;
      for (int i = 0; i < N_BTN; i++) begin
        db_cnt[i]   <= '0;
        hold_cnt[i] <= '0;
      end
    end else begin
      btn_level   <= level_nxt;
      btn_press   <= press_nxt;
      btn_release <= release_nxt;
      stuck       <= stuck_nxt;
      any_press   <= |press_nxt;
      for (int i = 0; i < N_BTN; i++) begin
        db_cnt[i]   <= db_nxt[i];
        hold_cnt[i] <= hold_nxt[i];
      end
    end
  end

endmodule
